game_sequencer: RTL and testbench

GAME_SEQUENCER -- requirements
Module: game_sequencer

---
 rtl/game_sequencer.sv | 178 +++++++++++++++++
 tb/tb_game_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// game_sequencer: keyboard-driven game state machine with frame/second timer.
//
// Ports:
//   clk          game/VGA clock
//   rst_n_in     asynchronous active-low reset
//   key_code     PS/2 set-2 scan byte, valid when key_valid is high
//   key_valid    one-cycle strobe qualifying key_code
//   vs           VGA vertical sync (clk-synchronous)
//   player_dead  outcome level from the datapath
//   goal_reached outcome level from the datapath
//   dirMove      held W/S/A/D bits {right,left,down,up}; zero outside PLAY
//   gameState    0 IDLE, 1 PLAY, 2 PAUSE, 3 LOSE, 4 WIN
//   game_reset   one-cycle pulse when a new game starts
//   time_left    remaining seconds
//   frame_tick   one-cycle pulse per vs rising edge
module game_sequencer #(
  parameter int FRAMES_PER_SEC = 60,
  parameter int TIME_LIMIT     = 99
) (
  input  logic       clk,
  input  logic       rst_n_in,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  input  logic       vs,
  input  logic       player_dead,
  input  logic       goal_reached,
  output logic [3:0] dirMove,
  output logic [2:0] gameState,
  output logic       game_reset,
  output logic [6:0] time_left,
  output logic       frame_tick
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PLAY  = 3'd1,
    S_PAUSE = 3'd2,
    S_LOSE  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam logic [7:0] K_BRK   = 8'hF0;
  localparam logic [7:0] K_EXT   = 8'hE0;
  localparam logic [7:0] K_W     = 8'h1D;
  localparam logic [7:0] K_S     = 8'h1B;
  localparam logic [7:0] K_A     = 8'h1C;
  localparam logic [7:0] K_D     = 8'h23;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_P     = 8'h4D;
  localparam logic [7:0] K_ESC   = 8'h76;

  localparam logic [7:0] FPS_LAST = 8'(FRAMES_PER_SEC - 1);
  localparam logic [6:0] TL_INIT  = 7'(TIME_LIMIT);

  state_t     state, state_nxt;
  logic       start;
  logic       brk_q, ext_q;
  logic [3:0] held_dir;
  logic       held_enter, held_p;
  logic       ev_enter, ev_p, ev_esc;
  logic       vs_q;
  logic [7:0] frame_cnt;

  // Scan decoder. Prefix bytes only arm flags; the next byte consumes them.
  // Extended codes are dropped so e.g. keypad/arrow variants never alias WASD.
  // Enter/P events fire only on the first make so typematic repeats are inert.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      held_dir   <= '0;
      held_enter <= 1'b0;
      held_p     <= 1'b0;
      ev_enter   <= 1'b0;
      ev_p       <= 1'b0;
      ev_esc     <= 1'b0;
    end else begin
      ev_enter <= 1'b0;
      ev_p     <= 1'b0;
      ev_esc   <= 1'b0;
      if (key_valid) begin
        if (key_code == K_BRK) begin
          brk_q <= 1'b1;
        end else if (key_code == K_EXT) begin
          ext_q <= 1'b1;
        end else begin
          brk_q <= 1'b0;
          ext_q <= 1'b0;
          if (!ext_q) begin
            case (key_code)
              K_W:     held_dir[0] <= !brk_q;
              K_S:     held_dir[1] <= !brk_q;
              K_A:     held_dir[2] <= !brk_q;
              K_D:     held_dir[3] <= !brk_q;
              K_ENTER: begin
                held_enter <= !brk_q;
                ev_enter   <= !brk_q && !held_enter;
              end
              K_P: begin
                held_p <= !brk_q;
                ev_p   <= !brk_q && !held_p;
              end
              K_ESC:   ev_esc <= !brk_q;
              default: ;
            endcase
          end
        end
      end
    end
  end

  // vs rising-edge detector, registered
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      vs_q       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      vs_q       <= vs;
      frame_tick <= vs & ~vs_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Esc beats everything; in PLAY an outcome beats a pause request.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    if (ev_esc) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ev_enter) begin
          state_nxt = S_PLAY;
          start     = 1'b1;
        end
        S_PLAY: begin
          if (player_dead)          state_nxt = S_LOSE;
          else if (goal_reached)    state_nxt = S_WIN;
          else if (time_left == '0) state_nxt = S_LOSE;
          else if (ev_p)            state_nxt = S_PAUSE;
        end
        S_PAUSE: if (ev_p) state_nxt = S_PLAY;
        S_LOSE, S_WIN: if (ev_enter) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Frame/second timer, only running in PLAY; time_left saturates at 0.
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_cnt  <= '0;
      time_left  <= TL_INIT;
      game_reset <= 1'b0;
    end else begin
      game_reset <= start;
      if (start) begin
        frame_cnt <= '0;
        time_left <= TL_INIT;
      end else if (state == S_PLAY && frame_tick) begin
        if (frame_cnt == FPS_LAST) begin
          frame_cnt <= '0;
          if (time_left != '0) time_left <= time_left - 7'd1;
        end else begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
    end
  end

  assign gameState = state;
  assign dirMove   = (state == S_PLAY) ? held_dir : 4'b0000;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;
  localparam int FPS = 4;
  localparam int TL  = 2;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_valid = 1'b0, vs = 1'b0, pd = 1'b0, gr = 1'b0;
  logic [3:0] dirMove;
  logic [2:0] gameState;
  logic       game_reset, frame_tick;
  logic [6:0] time_left;

  game_sequencer #(.FRAMES_PER_SEC(FPS), .TIME_LIMIT(TL)) dut (
    .clk(clk), .rst_n_in(rst_n), .key_code(key_code), .key_valid(key_valid),
    .vs(vs), .player_dead(pd), .goal_reached(gr), .dirMove(dirMove),
    .gameState(gameState), .game_reset(game_reset), .time_left(time_left),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  bit cmp_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Game-level view: a table of which scan codes are down, a set of key
  // events raised by the last byte, and the game's state/score variables.
  int m_state = 0, m_frames = 0, m_time = TL, m_ns;
  bit m_held [256];
  bit m_brk = 0, m_ext = 0, ev_enter = 0, ev_p = 0, ev_esc = 0;
  bit m_vs_prev = 0, m_tick = 0, m_grst = 0, m_start;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_frames = 0; m_time = TL;
      foreach (m_held[i]) m_held[i] = 0;
      m_brk = 0; m_ext = 0; ev_enter = 0; ev_p = 0; ev_esc = 0;
      m_vs_prev = 0; m_tick = 0; m_grst = 0;
    end else begin
      // game reacts to events raised by the previous byte
      m_ns = m_state; m_start = 0;
      if (ev_esc) m_ns = 0;
      else case (m_state)
        0: if (ev_enter) begin m_ns = 1; m_start = 1; end
        1: if (pd) m_ns = 3; else if (gr) m_ns = 4;
           else if (m_time == 0) m_ns = 3; else if (ev_p) m_ns = 2;
        2: if (ev_p) m_ns = 1;
        3, 4: if (ev_enter) m_ns = 0;
        default: m_ns = 0;
      endcase
      if (m_start) begin
        m_time = TL; m_frames = 0;
      end else if (m_state == 1 && m_tick) begin
        m_frames = (m_frames + 1) % FPS;
        if (m_frames == 0 && m_time > 0) m_time = m_time - 1;
      end
      m_state = m_ns;
      m_grst  = m_start;
      m_tick  = vs && !m_vs_prev;
      m_vs_prev = vs;
      ev_enter = 0; ev_p = 0; ev_esc = 0;
      if (key_valid) begin
        if (key_code == 8'hF0) m_brk = 1;
        else if (key_code == 8'hE0) m_ext = 1;
        else begin
          if (!m_ext) begin
            if (m_brk) m_held[key_code] = 0;
            else begin
              if (key_code == 8'h5A && !m_held[key_code]) ev_enter = 1;
              if (key_code == 8'h4D && !m_held[key_code]) ev_p = 1;
              if (key_code == 8'h76) ev_esc = 1;
              m_held[key_code] = 1;
            end
          end
          m_brk = 0; m_ext = 0;
        end
      end
    end
  end

  function automatic int exp_dir();
    if (m_state != 1) return 0;
    return {28'd0, m_held[8'h23], m_held[8'h1C], m_held[8'h1B], m_held[8'h1D]};
  endfunction

  // compare process
  always @(negedge clk) begin
    if (cmp_en && rst_n) begin
      chk("gameState", int'(gameState), m_state);
      chk("dirMove", int'(dirMove), exp_dir());
      chk("game_reset", int'(game_reset), int'(m_grst));
      chk("time_left", int'(time_left), m_time);
      chk("frame_tick", int'(frame_tick), int'(m_tick));
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b);
    @(negedge clk); key_code = b; key_valid = 1'b1;
    @(negedge clk); key_valid = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_edge();
    @(negedge clk); vs = 1'b1;
    @(negedge clk); vs = 1'b0;
  endtask

  task automatic start_game();
    send(8'hF0); send(8'h5A); send(8'h5A); cyc(1);
  endtask

  logic [7:0] pool [12] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h5A, 8'h5A,
                            8'h4D, 8'hF0, 8'hF0, 8'hE0, 8'h15, 8'h76};

  initial begin
    #23;
    chk("rst_state", int'(gameState), 0);
    chk("rst_dir", int'(dirMove), 0);
    chk("rst_grst", int'(game_reset), 0);
    chk("rst_tick", int'(frame_tick), 0);
    chk("rst_time", int'(time_left), TL);
    @(negedge clk); rst_n = 1'b1; cmp_en = 1;

    // start a game, then W make/repeat/break
    send(8'h5A);
    chk("enter_lat", int'(gameState), 0);
    cyc(1);
    chk("start_state", int'(gameState), 1);
    chk("start_pulse", int'(game_reset), 1);
    chk("start_time", int'(time_left), TL);
    cyc(1);
    chk("pulse_end", int'(game_reset), 0);
    send(8'hF0); send(8'h5A); send(8'h1D); send(8'h1D); cyc(1);
    chk("w_held", int'(dirMove), 1);
    send(8'hF0); send(8'h1D); cyc(1);
    chk("w_break", int'(dirMove), 0);

    // timer: FPS ticks per second, LOSE one cycle after reaching 0
    repeat (4) vs_edge();
    cyc(2);
    chk("time_1", int'(time_left), 1);
    repeat (4) vs_edge();
    cyc(1);
    chk("time_0", int'(time_left), 0);
    chk("zero_still_play", int'(gameState), 1);
    cyc(1);
    chk("timeout_lose", int'(gameState), 3);
    repeat (4) vs_edge();
    cyc(2);
    chk("time_sat", int'(time_left), 0);
    send(8'h5A); cyc(1);
    chk("lose_to_idle", int'(gameState), 0);

    // pause with typematic P, frozen timer
    start_game();
    chk("play2", int'(gameState), 1);
    send(8'h4D); send(8'h4D); send(8'h4D); cyc(1);
    chk("paused", int'(gameState), 2);
    repeat (20) vs_edge();
    cyc(2);
    chk("pause_frozen", int'(time_left), TL);
    send(8'hF0); send(8'h4D); send(8'h4D); cyc(1);
    chk("resume", int'(gameState), 1);

    // dead and goal together -> LOSE; dirMove masked in IDLE
    send(8'h23);
    @(negedge clk); pd = 1'b1; gr = 1'b1;
    @(negedge clk); pd = 1'b0; gr = 1'b0;
    chk("dead_prio", int'(gameState), 3);
    start_game();
    chk("lose_idle", int'(gameState), 0);
    chk("idle_mask", int'(dirMove), 0);

    // extended codes ignored
    start_game();
    chk("d_held_play", int'(dirMove), 8);
    send(8'hE0); send(8'h1D); cyc(1);
    chk("ext_make", int'(dirMove), 8);
    send(8'h1D); cyc(1);
    chk("w_make", int'(dirMove), 9);
    send(8'hE0); send(8'hF0); send(8'h1D); cyc(1);
    chk("ext_break", int'(dirMove), 9);

    // WIN then Esc, then async reset mid-game
    @(negedge clk); gr = 1'b1;
    @(negedge clk); gr = 1'b0;
    chk("win", int'(gameState), 4);
    send(8'h76);
    chk("esc_lat", int'(gameState), 4);
    cyc(1);
    chk("esc_idle", int'(gameState), 0);
    start_game();
    repeat (4) vs_edge();
    cyc(2);
    chk("pre_rst_time", int'(time_left), 1);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    chk("arst_state", int'(gameState), 0);
    chk("arst_dir", int'(dirMove), 0);
    chk("arst_grst", int'(game_reset), 0);
    chk("arst_time", int'(time_left), TL);
    chk("arst_tick", int'(frame_tick), 0);
    @(negedge clk); rst_n = 1'b1;
    cyc(3);
    chk("post_rst_idle", int'(gameState), 0);

    // randomized traffic checked every cycle by the compare process
    repeat (4000) begin
      @(negedge clk);
      key_valid = ($urandom % 3) == 0;
      key_code  = pool[$urandom % 12];
      vs        = $urandom % 2;
      pd        = ($urandom % 40) == 0;
      gr        = ($urandom % 60) == 0;
    end
    @(negedge clk); key_valid = 1'b0; pd = 1'b0; gr = 1'b0;
    cyc(2);
    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
